// File: rtl/pong_engine.sv
// Pong game-state engine: ball kinematics, paddles, collisions, serve timing,
// BCD scoring and match end, all advanced on the frame-rate tick enable.
module pong_engine #(
  parameter int W           = 10,
  parameter int VW          = 5,
  parameter int X_MIN       = 10,
  parameter int X_MAX       = 640,
  parameter int Y_MIN       = 5,
  parameter int Y_MAX       = 470,
  parameter int BALL        = 5,
  parameter int PAD_W       = 10,
  parameter int PAD_H       = 100,
  parameter int P1_X        = 15,
  parameter int P2_X        = 630,
  parameter int PAD_Y0      = 200,
  parameter int V0          = 1,
  parameter int VMAX        = 8,
  parameter int PV0         = 3,
  parameter int PVMAX       = 8,
  parameter int SERVE_TICKS = 50,
  parameter int WIN_SCORE   = 11
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  input  logic         tick,
  input  logic         p1_up,
  input  logic         p1_down,
  input  logic         p2_up,
  input  logic         p2_down,
  input  logic         pause,
  input  logic [1:0]   serve_dir,
  input  logic [W-1:0] serve_y,
  output logic [W-1:0] ball_x,
  output logic [W-1:0] ball_y,
  output logic [W-1:0] paddle1_y,
  output logic [W-1:0] paddle2_y,
  output logic [7:0]   score1,
  output logic [7:0]   score2,
  output logic [2:0]   state,
  output logic [1:0]   winner,
  output logic         score_evt
);

  localparam int SW = W + 2;
  localparam int CW = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;
  localparam int CX = (X_MIN + X_MAX - BALL) / 2;
  localparam int CY = (Y_MIN + Y_MAX - BALL) / 2;
  localparam logic [7:0] WIN_BCD = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};

  localparam logic signed [SW-1:0] K_Y_TOP   = SW'(Y_MIN);
  localparam logic signed [SW-1:0] K_Y_BOT   = SW'(Y_MAX - BALL);
  localparam logic signed [SW-1:0] K_X_L     = SW'(X_MIN);
  localparam logic signed [SW-1:0] K_X_R     = SW'(X_MAX - BALL);
  localparam logic signed [SW-1:0] K_P1_X    = SW'(P1_X);
  localparam logic signed [SW-1:0] K_P1_R    = SW'(P1_X + PAD_W);
  localparam logic signed [SW-1:0] K_P2_X    = SW'(P2_X);
  localparam logic signed [SW-1:0] K_P2_R    = SW'(P2_X + PAD_W);
  localparam logic signed [SW-1:0] K_BALL    = SW'(BALL);
  localparam logic signed [SW-1:0] K_PAD_H   = SW'(PAD_H);
  localparam logic signed [SW-1:0] K_PAD_BOT = SW'(Y_MAX - PAD_H);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  state_t st, st_n;
  logic signed [VW-1:0] vx, vy, vx_n, vy_n, vyw;
  logic [VW-1:0]        step, step_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [W-1:0]         bx_n, by_n, p1_n, p2_n, serve_c;
  logic [7:0]           s1_n, s2_n, s1_inc, s2_inc;
  logic [1:0]           win_n;
  logic                 evt_n, start, hit1, hit2, goal_l, goal_r;
  logic signed [SW-1:0] nx, ny, yw, p1_s, p2_s;

  assign state = st;

  function automatic logic [VW-1:0] mag(input logic signed [VW-1:0] v);
    return v[VW-1] ? VW'(-v) : VW'(v);
  endfunction

  function automatic logic [VW-1:0] bump(input logic [VW-1:0] m, input logic [VW-1:0] cap);
    return (m >= cap) ? cap : m + VW'(1);
  endfunction

  function automatic logic signed [VW-1:0] with_sign(input logic neg, input logic [VW-1:0] m);
    return neg ? -$signed(m) : $signed(m);
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] s);
    if (s[3:0] != 4'd9) return {s[7:4], s[3:0] + 4'd1};
    if (s[7:4] != 4'd9) return {s[7:4] + 4'd1, 4'd0};
    return 8'h00;
  endfunction

  // Paddle step with clamp; signed headroom keeps a step past the top from wrapping.
  function automatic logic [W-1:0] move_pad(input logic [W-1:0] y, input logic up,
                                            input logic dn, input logic [VW-1:0] s);
    logic signed [SW-1:0] t;
    t = $signed({2'b00, y});
    if (up && !dn)      t = t - $signed(SW'(s));
    else if (dn && !up) t = t + $signed(SW'(s));
    if (t < K_Y_TOP)        t = K_Y_TOP;
    else if (t > K_PAD_BOT) t = K_PAD_BOT;
    return t[W-1:0];
  endfunction

  assign start   = (p1_up | p1_down) & (p2_up | p2_down);
  assign serve_c = (serve_y < W'(Y_MIN))        ? W'(Y_MIN) :
                   (serve_y > W'(Y_MAX - BALL)) ? W'(Y_MAX - BALL) : serve_y;
  assign s1_inc  = bcd_inc(score1);
  assign s2_inc  = bcd_inc(score2);

  always_comb begin
    st_n   = st;
    bx_n   = ball_x;
    by_n   = ball_y;
    vx_n   = vx;
    vy_n   = vy;
    p1_n   = paddle1_y;
    p2_n   = paddle2_y;
    step_n = step;
    cnt_n  = cnt;
    s1_n   = score1;
    s2_n   = score2;
    win_n  = winner;
    evt_n  = 1'b0;

    nx   = $signed({2'b00, ball_x}) + SW'(vx);
    ny   = $signed({2'b00, ball_y}) + SW'(vy);
    p1_s = $signed({2'b00, paddle1_y});
    p2_s = $signed({2'b00, paddle2_y});

    if (ny <= K_Y_TOP) begin
      yw  = K_Y_TOP;
      vyw = $signed(mag(vy));
    end else if (ny >= K_Y_BOT) begin
      yw  = K_Y_BOT;
      vyw = -$signed(mag(vy));
    end else begin
      yw  = ny;
      vyw = vy;
    end

    // Direction gating replaces a hit latch: a receding ball can never re-hit.
    hit1 = vx[VW-1] && (nx <= K_P1_R) && (nx + K_BALL > K_P1_X) &&
           (ny + K_BALL > p1_s) && (ny < p1_s + K_PAD_H);
    hit2 = !vx[VW-1] && (vx != '0) && (nx + K_BALL >= K_P2_X) && (nx < K_P2_R) &&
           (ny + K_BALL > p2_s) && (ny < p2_s + K_PAD_H);
    goal_l = !hit1 && !hit2 && (nx <= K_X_L);
    goal_r = !hit1 && !hit2 && !goal_l && (nx >= K_X_R);

    if (tick) begin
      case (st)
        ST_IDLE: if (start) st_n = ST_SERVE;
        ST_SERVE: begin
          p1_n   = move_pad(paddle1_y, p1_up, p1_down, step);
          p2_n   = move_pad(paddle2_y, p2_up, p2_down, step);
          bx_n   = W'(CX);
          by_n   = serve_c;
          vx_n   = with_sign(serve_dir[0], VW'(V0));
          vy_n   = with_sign(serve_dir[1], VW'(V0));
          step_n = VW'(PV0);
          if (cnt == CW'(SERVE_TICKS - 1)) begin
            cnt_n = '0;
            st_n  = ST_PLAY;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        ST_PLAY: begin
          p1_n = move_pad(paddle1_y, p1_up, p1_down, step);
          p2_n = move_pad(paddle2_y, p2_up, p2_down, step);
          by_n = yw[W-1:0];
          vy_n = vyw;
          if (hit1) begin
            bx_n   = W'(P1_X + PAD_W);
            vx_n   = with_sign(1'b0, bump(mag(vx), VW'(VMAX)));
            vy_n   = with_sign(vyw[VW-1], bump(mag(vyw), VW'(VMAX)));
            step_n = bump(step, VW'(PVMAX));
          end else if (hit2) begin
            bx_n   = W'(P2_X - BALL);
            vx_n   = with_sign(1'b1, bump(mag(vx), VW'(VMAX)));
            vy_n   = with_sign(vyw[VW-1], bump(mag(vyw), VW'(VMAX)));
            step_n = bump(step, VW'(PVMAX));
          end else if (goal_l) begin
            bx_n  = W'(X_MIN);
            s2_n  = s2_inc;
            evt_n = 1'b1;
            if (WIN_SCORE != 0 && s2_inc == WIN_BCD) begin
              st_n  = ST_OVER;
              win_n = 2'b10;
            end else begin
              st_n = ST_SERVE;
            end
          end else if (goal_r) begin
            bx_n  = W'(X_MAX - BALL);
            s1_n  = s1_inc;
            evt_n = 1'b1;
            if (WIN_SCORE != 0 && s1_inc == WIN_BCD) begin
              st_n  = ST_OVER;
              win_n = 2'b01;
            end else begin
              st_n = ST_SERVE;
            end
          end else begin
            bx_n = nx[W-1:0];
            if (pause) st_n = ST_PAUSE;
          end
        end
        ST_PAUSE: if (!pause) st_n = ST_PLAY;
        ST_OVER: begin
          if (start) begin
            s1_n  = 8'h00;
            s2_n  = 8'h00;
            win_n = 2'b00;
            p1_n  = W'(PAD_Y0);
            p2_n  = W'(PAD_Y0);
            st_n  = ST_SERVE;
          end
        end
        default: st_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      st        <= ST_IDLE;
      ball_x    <= W'(CX);
      ball_y    <= W'(CY);
      vx        <= VW'(V0);
      vy        <= VW'(V0);
      paddle1_y <= W'(PAD_Y0);
      paddle2_y <= W'(PAD_Y0);
      step      <= VW'(PV0);
      cnt       <= '0;
      score1    <= 8'h00;
      score2    <= 8'h00;
      winner    <= 2'b00;
      score_evt <= 1'b0;
    end else begin
      st        <= st_n;
      ball_x    <= bx_n;
      ball_y    <= by_n;
      vx        <= vx_n;
      vy        <= vy_n;
      paddle1_y <= p1_n;
      paddle2_y <= p2_n;
      step      <= step_n;
      cnt       <= cnt_n;
      score1    <= s1_n;
      score2    <= s2_n;
      winner    <= win_n;
      score_evt <= evt_n;
    end
  end

endmodule

// File: doc/pong_engine.md
Name: pong_engine

Overview:
- Parametrised game-state engine for the VGA Pong design: ball kinematics, paddle motion, collisions, serve timing, BCD scoring and match end.
- Successor to the fixed-geometry game FSM, with these changes:
  - Field, object sizes, speeds and win score are parameters.
  - Motion is advanced by a frame-rate `tick` enable instead of a derived clock.
  - Paddle-hit detection is direction-gated and needs no hit latch.
  - Speed-up saturates.
  - A match-over state is added.
- Sits between the debounced key inputs and the pixel renderer; its outputs are top-left object coordinates.

Parameters:
- W, 10, coordinate width (unsigned)
- VW, 5, velocity width (signed, two's complement)
- X_MIN, 10, left goal line
- X_MAX, 640, right goal line
- Y_MIN, 5, top wall
- Y_MAX, 470, bottom wall
- BALL, 5, ball edge length (square)
- PAD_W, 10, paddle width
- PAD_H, 100, paddle height
- P1_X, 15, paddle 1 left x
- P2_X, 630, paddle 2 left x
- PAD_Y0, 200, paddle y after reset/new match
- V0, 1, serve speed magnitude (x and y)
- VMAX, 8, ball speed magnitude cap per axis
- PV0, 3, initial paddle step
- PVMAX, 8, paddle step cap
- SERVE_TICKS, 50, ticks spent in SERVE
- WIN_SCORE, 11, points to win (BCD compare); 0 = endless, 99 wraps to 00

Ports:
- CLOCK_50  in  1  system clock
- reset  in  1  synchronous, active-high
- tick  in  1  one-cycle game-step enable
- p1_up, p1_down, p2_up, p2_down  in  1 each  active-high debounced buttons
- pause  in  1  level; hold to pause
- serve_dir  in  2  [0]=1 serve left, [1]=1 serve up (random source)
- serve_y  in  W  random serve row
- ball_x, ball_y  out  W  ball top-left
- paddle1_y, paddle2_y  out  W  paddle tops
- score1, score2  out  8  two-digit BCD
- state  out  3  0 IDLE, 1 SERVE, 2 PLAY, 3 PAUSE, 4 OVER
- winner  out  2  00 none, 01 P1, 10 P2
- score_evt  out  1  one-cycle pulse on any point

Behaviour:
- Clock and reset:
  - One clock, CLOCK_50. Reset is synchronous, active-high, and has priority over everything, including mid-rally.
  - Reset values: ball at (CX=(X_MIN+X_MAX-BALL)/2, CY=(Y_MIN+Y_MAX-BALL)/2); paddles at PAD_Y0; scores 00; state IDLE; winner 00; score_evt 0; vx=+V0, vy=+V0; paddle step PV0; serve counter 0.
- Tick gating: all state and position updates happen only on cycles with tick=1. score_evt is a registered pulse and goes low on the cycle after it asserts.
- IDLE: (p1_up|p1_down)&(p2_up|p2_down) -> SERVE.
- SERVE (on each tick):
  - Ball at CX, serve_y clamped to [Y_MIN, Y_MAX-BALL].
  - vx = serve_dir[0] ? -V0 : +V0; vy = serve_dir[1] ? -V0 : +V0; paddle step = PV0.
  - Counter increments; the tick on which it equals SERVE_TICKS-1 -> PLAY, counter cleared.
  - Paddles move during SERVE.
- PLAY, paddles (each tick):
  - Up alone: y -= step. Down alone: y += step. Both or neither: hold.
  - Clamp to [Y_MIN, Y_MAX-PAD_H].
- PLAY, ball arithmetic: next positions are computed in W+2-bit signed to avoid wrap; nx=ball_x+vx, ny=ball_y+vy.
- Walls:
  - ny<=Y_MIN: y=Y_MIN, vy=+|vy|.
  - ny>=Y_MAX-BALL: y=Y_MAX-BALL, vy=-|vy|.
- Paddle 1 hit (checked only while vx<0):
  - Condition: nx<=P1_X+PAD_W, nx+BALL>P1_X, ny+BALL>paddle1_y, ny<paddle1_y+PAD_H.
  - Response: x=P1_X+PAD_W; vx=+min(|vx|+1,VMAX); |vy|=min(|vy|+1,VMAX) keeping the post-wall sign; step=min(step+1,PVMAX).
- Paddle 2 hit (checked only while vx>0): mirror of paddle 1 using P2_X, with x=P2_X-BALL.
- Wall and paddle response on the same tick: both apply, since the axes are independent.
- Goals (evaluated only when no paddle hit that tick):
  - nx<=X_MIN: P2 scores.
  - nx>=X_MAX-BALL: P1 scores.
  - On a goal: the score BCD-increments (ones 9 -> 0 with tens+1; 99 -> 00), score_evt=1.
  - If the new score equals WIN_SCORE (and WIN_SCORE!=0) -> OVER with winner set; else -> SERVE.
- Pause:
  - pause=1 in PLAY with no goal that tick -> PAUSE; a goal takes precedence.
  - PAUSE freezes everything. pause=0 -> PLAY.
  - pause is ignored in IDLE, SERVE and OVER.
- OVER: positions frozen. IDLE start condition -> scores 00, winner 00, paddles PAD_Y0, -> SERVE.

Test Plan:
- Reset, then tick with p1_up&p2_down -> state 1. After 50 ticks -> state 2, ball_x=322, vx=±1 per serve_dir[0].
- Ball at y=6, vy=-3 -> ball_y=5, vy=+3. Paddle1_y=5 with p1_up -> stays 5. p1_up&p1_down -> no move.
- Ball x=26 moving left, vx=-1, vy=+1, within paddle1 span -> x=25, vx=+2, vy=+2, step 4. After repeated hits vx caps at 8, step caps at 8.
- Ball x=11, vx=-2, no paddle -> score2 00->01, score_evt one-cycle pulse, state 1. Preset score1=09 and P1 scores -> 10.
- score1=10, WIN_SCORE=11, P1 scores -> state 4, winner 01. Start press -> scores 00, state 1.
- pause held mid-rally -> state 3, no position change over 20 ticks. Release -> resumes from the same position. reset mid-PAUSE -> all reset values next cycle.
